// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock flexible FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 6;

  typedef enum logic {
    RD_STANDARD = 1'b0,
    RD_FWFT     = 1'b1
  } read_mode_e;

  typedef logic [FIFO_ADDR_WIDTH:0] count_t;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port storage: one write port, read port either registered or combinational.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter bit          REG_READ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = REG_READ ? rdata_q : mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with exact count, programmable thresholds, sticky errors
// and selectable standard / first-word-fall-through read.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  half,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned        DEPTH    = fifo_depth(ADDR_WIDTH);
  localparam int unsigned        CW       = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] HALF_C  = CW'(DEPTH / 2);
  localparam bit                 REG_READ = (read_mode_e'(FWFT) == RD_STANDARD);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  // Flags decode the registered count so they move on the same edge as count.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign half         = (count_q >= HALF_C);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);

  always_comb begin
    wr_acc      = wr_en & ~full;
    rd_acc      = rd_en & ~empty;
    wptr_d      = wptr_q + ADDR_WIDTH'(wr_acc);
    rptr_d      = rptr_q + ADDR_WIDTH'(rd_acc);
    count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
    // Set takes priority over a coincident clear.
    overflow_d  = (wr_en & full)  | (overflow_q  & ~clr_err);
    underflow_d = (rd_en & empty) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_READ   (REG_READ)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rptr_q),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench: standard and FWFT instances driven by the same stimulus.
module tb_sync_fifo_flex;
  import fifo_pkg::*;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic [6:0] af_thresh;
  logic [6:0] ae_thresh;
  logic       clr_err;

  logic [7:0] data_out_s, data_out_f;
  count_t     count_s, count_f;
  logic       full_s, empty_s, half_s, af_s, ae_s, ovf_s, unf_s;
  logic       full_f, empty_f, half_f, af_f, ae_f, ovf_f, unf_f;

  int n_checks = 0;
  int n_fails  = 0;

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .FWFT(1'b0)) u_dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
    .data_out(data_out_s), .count(count_s), .full(full_s), .empty(empty_s),
    .half(half_s), .almost_full(af_s), .almost_empty(ae_s),
    .overflow(ovf_s), .underflow(unf_s)
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .FWFT(1'b1)) u_dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
    .data_out(data_out_f), .count(count_f), .full(full_f), .empty(empty_f),
    .half(half_f), .almost_full(af_f), .almost_empty(ae_f),
    .overflow(ovf_f), .underflow(unf_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] wv;
  logic [7:0] rv;

  initial begin
    rst = 1'b1; wr_en = 1'b0; data_in = 8'h00; rd_en = 1'b0;
    af_thresh = 7'd0; ae_thresh = 7'd4; clr_err = 1'b0;

    // Reset state
    #12;
    check("rst_count", count_s, 0);
    check("rst_empty", empty_s, 1);
    check("rst_full", full_s, 0);
    check("rst_half", half_s, 0);
    check("rst_ae", ae_s, 1);
    check("rst_af_thr0", af_s, 1);
    check("rst_dout_std", data_out_s, 0);
    check("rst_ovf", ovf_s, 0);
    check("rst_unf", unf_f, 0);
    af_thresh = 7'd60;
    #1;
    check("rst_af_thr60", af_s, 0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: fill to full
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; data_in = 8'(i);
      tick();
      check("t1_count", count_s, i + 1);
      check("t1_half", half_s, (i + 1) >= 32);
      check("t1_full", full_s, (i + 1) == 64);
    end
    check("t1_count_fwft", count_f, 64);
    data_in = 8'hFF;
    tick();
    wr_en = 1'b0;
    check("t1_ovf", ovf_s, 1);
    check("t1_ovf_count", count_s, 64);
    af_thresh = 7'd65; #1;
    check("t1_af_above_depth", af_s, 0);
    af_thresh = 7'd64; #1;
    check("t1_af_eq_depth", af_s, 1);
    af_thresh = 7'd60;
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("t1_ovf_clr", ovf_s, 0);

    // 2: simultaneous wr/rd while full
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hEE;
    check("t2_head_fwft", data_out_f, 8'h00);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("t2_count", count_s, 63);
    check("t2_full", full_s, 0);
    check("t2_dout_std", data_out_s, 8'h00);
    check("t2_ovf", ovf_s, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;

    // 1 (cont): drain in order, 0xEE must not appear
    for (int i = 1; i < 64; i++) begin
      rd_en = 1'b1;
      check("t1_rd_fwft", data_out_f, 8'(i));
      tick();
      check("t1_rd_std", data_out_s, 8'(i));
    end
    rd_en = 1'b0;
    check("t1_drained_count", count_s, 0);
    check("t1_drained_empty", empty_f, 1);
    check("t1_no_unf", unf_s, 0);

    // 3: thresholds af=60, ae=4
    for (int i = 0; i < 59; i++) begin
      wr_en = 1'b1; data_in = 8'(8'h40 + i); tick();
    end
    check("t3_count59", count_s, 59);
    check("t3_af59", af_s, 0);
    check("t3_ae59", ae_s, 0);
    tick();
    wr_en = 1'b0;
    check("t3_af60", af_s, 1);
    for (int i = 0; i < 55; i++) begin
      rd_en = 1'b1; tick();
    end
    rd_en = 1'b0;
    check("t3_count5", count_s, 5);
    check("t3_ae5", ae_s, 0);
    check("t3_af5", af_s, 0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t3_count4", count_s, 4);
    check("t3_ae4", ae_f, 1);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; tick();
    end
    rd_en = 1'b0;
    check("t3_empty", empty_s, 1);

    // 4: FWFT presentation and sticky underflow
    wr_en = 1'b1; data_in = 8'hA5; tick(); wr_en = 1'b0;
    check("t4_fwft_dout", data_out_f, 8'hA5);
    check("t4_fwft_empty", empty_f, 0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t4_empty", empty_f, 1);
    check("t4_count", count_f, 0);
    check("t4_std_dout", data_out_s, 8'hA5);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t4_unf_f", unf_f, 1);
    check("t4_unf_s", unf_s, 1);
    check("t4_unf_count", count_f, 0);
    clr_err = 1'b1; tick();
    check("t4_unf_clr", unf_f, 0);
    rd_en = 1'b1; tick();
    check("t4_set_wins", unf_f, 1);
    rd_en = 1'b0; tick(); clr_err = 1'b0;
    check("t4_unf_clr2", unf_f, 0);

    // 5: streaming at count=10 across pointer wrap
    wv = 8'h80; rv = 8'h80;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; data_in = wv; tick(); wv = wv + 8'd1;
    end
    check("t5_count_pre", count_s, 10);
    for (int i = 0; i < 100; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; data_in = wv;
      check("t5_fwft_head", data_out_f, rv);
      tick();
      check("t5_std_dout", data_out_s, rv);
      check("t5_count", count_s, 10);
      wv = wv + 8'd1; rv = rv + 8'd1;
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_en = 1'b1;
      check("t5_drain_fwft", data_out_f, rv);
      tick();
      check("t5_drain_std", data_out_s, rv);
      rv = rv + 8'd1;
    end
    rd_en = 1'b0;
    check("t5_empty", empty_s, 1);

    // 6: asynchronous reset mid-stream
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t6_unf_pre", unf_s, 1);
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; data_in = 8'(8'h20 + i); tick();
    end
    check("t6_count20", count_s, 20);
    data_in = 8'h55;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    wr_en = 1'b0;
    check("t6_rst_count", count_s, 0);
    check("t6_rst_empty", empty_s, 1);
    check("t6_rst_ovf", ovf_s, 0);
    check("t6_rst_unf", unf_s, 0);
    check("t6_rst_dout", data_out_s, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    wr_en = 1'b1; data_in = 8'h11; tick(); wr_en = 1'b0;
    check("t6_count1", count_s, 1);
    check("t6_fwft_dout", data_out_f, 8'h11);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t6_std_dout", data_out_s, 8'h11);
    check("t6_empty", empty_s, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
